clock_mode_ctrl: RTL
====================

CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 30: inactivity limit in a set state, in clk cycles.
REQ-002 SHALL have parameter RING_CYCLES, default 60: maximum buzzer duration, in clk cycles.
REQ-003 SHALL have port clk  in  1  single system clock, rising-edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mode_btn  in  1  raw asynchronous mode button level.
REQ-006 SHALL have port inc_btn  in  1  raw asynchronous increment button level.
REQ-007 SHALL have port sel_btn  in  1  raw asynchronous select button level.
REQ-008 SHALL have port time_ack  in  1  set-time block finished.
REQ-009 SHALL have port alarm_ack  in  1  set-alarm block finished.
REQ-010 SHALL have port alarm_match  in  1  level, current time equals alarm time.
REQ-011 SHALL have port alarm_armed  in  1  alarm on/off setting.
REQ-012 SHALL have port set_time_en  out  1  enable to set-time block.
REQ-013 SHALL have port set_alarm_en  out  1  enable to set-alarm block.
REQ-014 SHALL have port mode_pulse  out  1  one-cycle mode strobe to the enabled set block.
REQ-015 SHALL have port inc_pulse  out  1  one-cycle increment strobe to the enabled set block.
REQ-016 SHALL have port time_run  out  1  timekeeping counter enable.
REQ-017 SHALL have port buzzer  out  1  alarm sounder drive.
REQ-018 SHALL have port state  out  2  IDLE=0, SET_TIME=1, SET_ALARM=2, RINGING=3.

Function
REQ-019 Each button SHALL pass a 2-flop synchronizer, then a registered rising-edge detector; input high before edge k -> internal pulse high for exactly the cycle after edge k+2; a held button yields one pulse.
REQ-020 FSM IDLE: sel pulse -> SET_TIME; rising edge of (alarm_match AND alarm_armed) -> RINGING; mode/inc pulses discarded.
REQ-021 SET_TIME: time_ack -> IDLE; sel pulse -> SET_ALARM; timeout -> IDLE.
REQ-022 SET_ALARM: alarm_ack -> IDLE; sel pulse -> IDLE; timeout -> IDLE.
REQ-023 RINGING: any button pulse -> IDLE, pulse consumed, not forwarded; RING_CYCLES elapsed in RINGING -> IDLE.
REQ-024 Priority within one cycle: ack > timeout > sel pulse; in IDLE, sel pulse > alarm edge, and the lost alarm edge is not retried.
REQ-025 Alarm edge detection SHALL run in all states; an edge occurring outside IDLE SHALL be dropped (no deferred ring).
REQ-026 Outputs SHALL be registered: set_time_en=(state==SET_TIME), set_alarm_en=(state==SET_ALARM), buzzer=(state==RINGING), time_run=(state!=SET_TIME), all valid the cycle the state is entered.
REQ-027 mode_pulse/inc_pulse SHALL forward internal pulses only while in SET_TIME or SET_ALARM and not in a cycle whose transition leaves that state.
REQ-028 Inactivity counter SHALL clear on state change and on any button pulse, increment each cycle in set states, and force IDLE when it reaches TIMEOUT_CYCLES-1; width ceil(log2(TIMEOUT_CYCLES)), no wrap.
REQ-029 Ring counter SHALL clear on entering RINGING, exit at RING_CYCLES-1, width ceil(log2(RING_CYCLES)).
REQ-030 Acks SHALL be ignored when their block is not enabled.

Reset
REQ-031 rst low SHALL asynchronously force state=IDLE, all counters, synchronizer and edge flops to 0, set_time_en=0, set_alarm_en=0, mode_pulse=0, inc_pulse=0, buzzer=0, time_run=1.
REQ-032 Reset mid-SET or mid-RINGING SHALL abort immediately; a button held through reset release SHALL NOT produce a pulse until released and pressed again.

Verification
REQ-033 sel_btn high 1 cycle in IDLE -> state=1, set_time_en=1, time_run=0 three cycles after press edge.
REQ-034 In SET_TIME, inc_btn pressed 4 times -> exactly 4 one-cycle inc_pulse; time_ack=1 -> next cycle state=0, set_time_en=0, time_run=1.
REQ-035 alarm_armed=1, alarm_match rises in IDLE -> state=3, buzzer=1; inc_btn press -> buzzer=0, state=0, no inc_pulse.
REQ-036 RINGING with no buttons -> buzzer high exactly 60 cycles, then state=0; alarm_match held high does not re-trigger.
REQ-037 SET_ALARM idle 30 cycles -> state=0; same cycle alarm_ack and sel pulse -> state=0 (not SET_TIME).
REQ-038 rst low during RINGING with inc_btn held -> buzzer=0 asynchronously; no inc pulse after release of rst until inc_btn re-pressed.

Source files
------------

// File: rtl/clock_mode_ctrl.sv
// Clock/alarm front-panel mode controller: button conditioning, set/ring FSM,
// inactivity and ring-duration timers, registered panel outputs.
`timescale 1ns/1ps

module clock_mode_ctrl_btn (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_pulse
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic       r_armed;
  logic       r_pulse;
  logic [1:0] r_warm;

  // r_warm marks when r_sync2 carries a real post-reset sample; r_armed then
  // waits for a low level so a button held through reset gives no pulse.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      r_pulse <= 1'b0;
      r_warm  <= 2'b00;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_warm  <= {r_warm[0], 1'b1};
      r_armed <= r_armed | (r_warm[1] & ~r_sync2);
      r_pulse <= r_sync2 & ~r_prev & r_armed;
    end
  end

  assign o_pulse = r_pulse;

endmodule

module clock_mode_ctrl #(
  parameter int TIMEOUT_CYCLES = 30,
  parameter int RING_CYCLES    = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       sel_btn,
  input  logic       time_ack,
  input  logic       alarm_ack,
  input  logic       alarm_match,
  input  logic       alarm_armed,
  output logic       set_time_en,
  output logic       set_alarm_en,
  output logic       mode_pulse,
  output logic       inc_pulse,
  output logic       time_run,
  output logic       buzzer,
  output logic [1:0] state
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = (RING_CYCLES > 1) ? $clog2(RING_CYCLES) : 1;
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RING_MAX = RW'(RING_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SET_TIME  = 2'd1,
    ST_SET_ALARM = 2'd2,
    ST_RINGING   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_idle_cnt;
  logic [RW-1:0] r_ring_cnt;
  logic          r_alarm_prev;
  logic          r_set_time_en;
  logic          r_set_alarm_en;
  logic          r_mode_pulse;
  logic          r_inc_pulse;
  logic          r_time_run;
  logic          r_buzzer;

  logic w_mode_p;
  logic w_inc_p;
  logic w_sel_p;
  logic w_any_p;
  logic w_alarm_lvl;
  logic w_alarm_edge;
  logic w_in_set;
  logic w_timeout;
  logic w_ring_done;
  logic w_change;
  logic w_fwd;

  clock_mode_ctrl_btn u_mode_btn (.i_clk(clk), .i_rst(rst), .i_btn(mode_btn), .o_pulse(w_mode_p));
  clock_mode_ctrl_btn u_inc_btn  (.i_clk(clk), .i_rst(rst), .i_btn(inc_btn),  .o_pulse(w_inc_p));
  clock_mode_ctrl_btn u_sel_btn  (.i_clk(clk), .i_rst(rst), .i_btn(sel_btn),  .o_pulse(w_sel_p));

  assign w_any_p      = w_mode_p | w_inc_p | w_sel_p;
  assign w_alarm_lvl  = alarm_match & alarm_armed;
  assign w_alarm_edge = w_alarm_lvl & ~r_alarm_prev;
  assign w_in_set     = (r_state == ST_SET_TIME) || (r_state == ST_SET_ALARM);
  assign w_timeout    = w_in_set && (r_idle_cnt == TO_MAX);
  assign w_ring_done  = (r_state == ST_RINGING) && (r_ring_cnt == RING_MAX);
  assign w_change     = (w_next != r_state);
  assign w_fwd        = w_in_set && !w_change;

  // Next state: ack beats timeout beats select; in IDLE select beats alarm.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_p) begin
          w_next = ST_SET_TIME;
        end else if (w_alarm_edge) begin
          w_next = ST_RINGING;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_SET_TIME: begin
        if (time_ack || w_timeout) begin
          w_next = ST_IDLE;
        end else if (w_sel_p) begin
          w_next = ST_SET_ALARM;
        end else begin
          w_next = ST_SET_TIME;
        end
      end
      ST_SET_ALARM: begin
        if (alarm_ack || w_timeout || w_sel_p) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_SET_ALARM;
        end
      end
      ST_RINGING: begin
        if (w_any_p || w_ring_done) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_RINGING;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register and alarm-level history; the alarm edge is evaluated in
  // every state but only IDLE acts on it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_alarm_prev <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_alarm_prev <= w_alarm_lvl;
    end
  end

  // Inactivity and ring timers; both saturate rather than wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idle_cnt <= {TW{1'b0}};
      r_ring_cnt <= {RW{1'b0}};
    end else begin
      if (w_change || w_any_p) begin
        r_idle_cnt <= {TW{1'b0}};
      end else if (w_in_set && (r_idle_cnt != TO_MAX)) begin
        r_idle_cnt <= r_idle_cnt + TW'(1);
      end else begin
        r_idle_cnt <= r_idle_cnt;
      end
      if (w_change) begin
        r_ring_cnt <= {RW{1'b0}};
      end else if ((r_state == ST_RINGING) && (r_ring_cnt != RING_MAX)) begin
        r_ring_cnt <= r_ring_cnt + RW'(1);
      end else begin
        r_ring_cnt <= r_ring_cnt;
      end
    end
  end

  // Panel outputs decoded from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_set_time_en  <= 1'b0;
      r_set_alarm_en <= 1'b0;
      r_buzzer       <= 1'b0;
      r_time_run     <= 1'b1;
      r_mode_pulse   <= 1'b0;
      r_inc_pulse    <= 1'b0;
    end else begin
      r_set_time_en  <= (w_next == ST_SET_TIME);
      r_set_alarm_en <= (w_next == ST_SET_ALARM);
      r_buzzer       <= (w_next == ST_RINGING);
      r_time_run     <= (w_next != ST_SET_TIME);
      r_mode_pulse   <= w_fwd & w_mode_p;
      r_inc_pulse    <= w_fwd & w_inc_p;
    end
  end

  assign set_time_en  = r_set_time_en;
  assign set_alarm_en = r_set_alarm_en;
  assign buzzer       = r_buzzer;
  assign time_run     = r_time_run;
  assign mode_pulse   = r_mode_pulse;
  assign inc_pulse    = r_inc_pulse;
  assign state        = r_state;

endmodule
